// File: rtl/stream_credit_gate_pkg.sv
// Shared types and helpers for the stream credit gate: FSM encoding,
// counter sizing and the statistics counter width.
package stream_credit_gate_pkg;

  localparam int unsigned STAT_WIDTH = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } gate_state_e;

  // Bits needed to hold every count from 0 up to max_elems inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_elems);
    return $clog2(max_elems + 1);
  endfunction

endpackage

// File: rtl/stream_credit_gate_skid.sv
// Two-entry skid buffer with fully registered outputs; one cycle of latency
// when empty, never drops or reorders, holds its output while stalled.
module stream_credit_gate_skid #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o
);

  logic                  out_valid_q, out_valid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  push;
  logic                  out_free;

  assign push     = valid_i && !skid_valid_q;
  assign out_free = !out_valid_q || ready_i;

  // Output register refills from the skid entry first so order is preserved.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = push;
        if (push) begin
          out_data_d = data_i;
        end
      end
    end else if (push) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign ready_o = !skid_valid_q;
  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;
  assign empty_o = !out_valid_q && !skid_valid_q;

endmodule

// File: rtl/stream_credit_gate.sv
// AXI-Stream gate bounding the number of elements in flight downstream, with
// netted multi-release, sticky underflow flag and a drain handshake.
// Define STREAM_CREDIT_GATE_STATS_EN to build the credit-stall cycle counter.
module stream_credit_gate
  import stream_credit_gate_pkg::*;
#(
  parameter  int unsigned MAX_NUMBER_OF_ELEMENTS = 128,
  parameter  int unsigned STREAM_WIDTH           = 32,
  parameter  int unsigned KEEP_WIDTH             = 1,
  parameter  int unsigned RELEASE_WIDTH          = 2,
  localparam int unsigned CNT_WIDTH              = cnt_width(MAX_NUMBER_OF_ELEMENTS)
) (
  input  logic                     aclk,
  input  logic                     resetn,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  input  logic [STREAM_WIDTH-1:0]  s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]    s_axis_tkeep,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic [STREAM_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]    m_axis_tkeep,
  input  logic [RELEASE_WIDTH-1:0] sigRelease,
  input  logic                     drainReq,
  output logic                     drained,
  output logic                     released,
  output logic [CNT_WIDTH-1:0]     inFlight,
  output logic                     errUnderflow,
  output logic [STAT_WIDTH-1:0]    statStallCycles
);

  localparam int unsigned SUM_WIDTH =
    (RELEASE_WIDTH > CNT_WIDTH + 1) ? RELEASE_WIDTH : CNT_WIDTH + 1;
  localparam int unsigned PAYLOAD_WIDTH = STREAM_WIDTH + KEEP_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_NUMBER_OF_ELEMENTS);

  gate_state_e              state_q, state_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     err_q, err_d;
  logic                     released_q, released_d;
  logic                     drained_q, drained_d;
  logic                     gate_open_q, gate_open_d;
  logic                     skid_ready;
  logic                     skid_empty;
  logic                     acc;
  logic [SUM_WIDTH-1:0]     sum;
  logic [SUM_WIDTH-1:0]     rel;
  logic [PAYLOAD_WIDTH-1:0] m_payload;

  // gate_open_q is low in reset, which keeps s_axis_tready low until the first edge.
  assign s_axis_tready = gate_open_q && skid_ready;
  assign acc           = s_axis_tvalid && s_axis_tready;

  stream_credit_gate_skid #(
    .DATA_WIDTH(PAYLOAD_WIDTH)
  ) u_skid (
    .clk_i   (aclk),
    .rst_ni  (resetn),
    .valid_i (acc),
    .ready_o (skid_ready),
    .data_i  ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
    .valid_o (m_axis_tvalid),
    .ready_i (m_axis_tready),
    .data_o  (m_payload),
    .empty_o (skid_empty)
  );

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = m_payload;

  // Accept and release are netted; an over-release clamps to zero and latches the error.
  always_comb begin
    sum   = SUM_WIDTH'(cnt_q) + SUM_WIDTH'(acc);
    rel   = SUM_WIDTH'(sigRelease);
    cnt_d = '0;
    err_d = err_q;
    if (rel > sum) begin
      err_d = 1'b1;
    end else begin
      cnt_d = CNT_WIDTH'(sum - rel);
    end
    released_d = (cnt_d == '0);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (drainReq) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!drainReq) begin
          state_d = RUN;
        end else if ((cnt_d == '0) && skid_empty) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!drainReq) begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
    drained_d   = (state_q == DONE) && (state_d == DONE);
    gate_open_d = (cnt_d < MAX_CNT) && (state_d == RUN);
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      released_q  <= 1'b1;
      drained_q   <= 1'b0;
      gate_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      released_q  <= released_d;
      drained_q   <= drained_d;
      gate_open_q <= gate_open_d;
    end
  end

  assign inFlight     = cnt_q;
  assign released     = released_q;
  assign drained      = drained_q;
  assign errUnderflow = err_q;

`ifdef STREAM_CREDIT_GATE_STATS_EN
  logic                  stall;
  logic [STAT_WIDTH-1:0] stall_q, stall_d;

  // A credit stall: upstream offers, the buffer has room, only the count blocks.
  assign stall = s_axis_tvalid && skid_ready && (state_q == RUN) && (cnt_q == MAX_CNT);

  always_comb begin
    stall_d = stall_q;
    if (stall && (stall_q != '1)) begin
      stall_d = stall_q + STAT_WIDTH'(1);
    end
  end

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign statStallCycles = stall_q;
`else
  assign statStallCycles = '0;
`endif

endmodule

// File: tb/tb_stream_credit_gate.sv
// Randomized bench for stream_credit_gate against a queue/arithmetic model,
// with directed scenarios pinning the model to hand-computed values.
module tb_stream_credit_gate;

  localparam int unsigned MAXN = 4;
  localparam int unsigned SW   = 32;
  localparam int unsigned KW   = 4;
  localparam int unsigned RW   = 2;
  localparam int unsigned CW   = 3;
  localparam int unsigned PW   = SW + KW + 1;
`ifdef STREAM_CREDIT_GATE_STATS_EN
  localparam int unsigned EXP_STALL = 5;
`else
  localparam int unsigned EXP_STALL = 0;
`endif

  logic          aclk = 1'b0;
  logic          resetn = 1'b1;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic          s_axis_tlast = 1'b0;
  logic [SW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b1;
  logic          m_axis_tlast;
  logic [SW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [RW-1:0] sigRelease = '0;
  logic          drainReq = 1'b0;
  logic          drained;
  logic          released;
  logic [CW-1:0] inFlight;
  logic          errUnderflow;
  logic [31:0]   statStallCycles;

  always #5 aclk = ~aclk;

  stream_credit_gate #(
    .MAX_NUMBER_OF_ELEMENTS(MAXN),
    .STREAM_WIDTH(SW),
    .KEEP_WIDTH(KW),
    .RELEASE_WIDTH(RW)
  ) dut (
    .aclk(aclk), .resetn(resetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
    .sigRelease(sigRelease), .drainReq(drainReq), .drained(drained), .released(released),
    .inFlight(inFlight), .errUnderflow(errUnderflow), .statStallCycles(statStallCycles)
  );

  // Reference model: FIFO contents, credit count, mode (0 run, 1 drain, 2 done).
  logic [PW-1:0] mq[$];
  logic [PW-1:0] sent[$];
  logic [PW-1:0] got[$];
  int            m_cnt;
  bit            m_err;
  int            m_mode;
  int            m_age;
  bit            m_oor;
  logic [31:0]   m_stat;
  bit            last_acc;
  int            dut_acc = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_rdy();
    return m_oor && (mq.size() < 2) && (m_cnt < int'(MAXN)) && (m_mode == 0);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_err = 0; m_mode = 0; m_age = 0; m_oor = 0; m_stat = '0; last_acc = 0;
  endtask

  task automatic new_payload();
    s_axis_tdata = $urandom;
    s_axis_tkeep = KW'($urandom);
    s_axis_tlast = 1'($urandom);
  endtask

  task automatic check_outputs();
    chk("s_tready", 64'(s_axis_tready), 64'(m_rdy()));
    chk("m_tvalid", 64'(m_axis_tvalid), 64'(mq.size() > 0));
    if (mq.size() > 0) chk("m_payload", 64'({m_axis_tlast, m_axis_tkeep, m_axis_tdata}), 64'(mq[0]));
    chk("inFlight", 64'(inFlight), 64'(m_cnt));
    chk("released", 64'(released), 64'(m_cnt == 0));
    chk("errUnderflow", 64'(errUnderflow), 64'(m_err));
    chk("drained", 64'(drained), 64'((m_mode == 2) && (m_age >= 1)));
    chk("statStall", 64'(statStallCycles), 64'(m_stat));
  endtask

  task automatic model_step();
    bit acc, stall, empty;
    int sum, nxt, nm;
    acc   = s_axis_tvalid && m_rdy();
    stall = s_axis_tvalid && (mq.size() < 2) && (m_mode == 0) && (m_cnt == int'(MAXN));
    sum   = m_cnt + int'(acc);
    if (int'(sigRelease) > sum) begin
      nxt = 0; m_err = 1;
    end else begin
      nxt = sum - int'(sigRelease);
    end
    empty = (mq.size() == 0);
    nm = m_mode;
    if (m_mode == 0 && drainReq) nm = 1;
    else if (m_mode == 1 && !drainReq) nm = 0;
    else if (m_mode == 1 && nxt == 0 && empty) nm = 2;
    else if (m_mode == 2 && !drainReq) nm = 0;
    m_age  = (nm == 2 && m_mode == 2) ? m_age + 1 : 0;
    m_mode = nm;
    if (mq.size() > 0 && m_axis_tready) void'(mq.pop_front());
    if (acc) begin
      mq.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
      sent.push_back({s_axis_tlast, s_axis_tkeep, s_axis_tdata});
    end
    m_cnt = nxt;
    m_oor = 1;
`ifdef STREAM_CREDIT_GATE_STATS_EN
    if (stall && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 32'd1;
`endif
    last_acc = acc;
  endtask

  task automatic cycle();
    check_outputs();
    if (s_axis_tvalid && s_axis_tready) dut_acc++;
    if (m_axis_tvalid && m_axis_tready) got.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
    model_step();
    @(posedge aclk);
    #1;
    if (last_acc) new_payload();
  endtask

  task automatic seq_check(input string name, input bit need_all);
    int bad;
    bad = 0;
    for (int i = 0; i < got.size(); i++) begin
      if (i >= sent.size() || got[i] !== sent[i]) bad++;
    end
    if (need_all && got.size() != sent.size()) bad++;
    chk(name, 64'(bad), 64'd0);
    got.delete();
    sent.delete();
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    s_axis_tvalid = 1'b0; sigRelease = '0; drainReq = 1'b0; m_axis_tready = 1'b1;
    #1;
    model_reset();
    chk("rst_inflight", 64'(inFlight), 64'd0);
    chk("rst_released", 64'(released), 64'd1);
    chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
    chk("rst_stat", 64'(statStallCycles), 64'd0);
    check_outputs();
    repeat (2) @(posedge aclk);
    #2;
    resetn = 1'b1;
    #1;
  endtask

  task automatic drain_all(input string name);
    s_axis_tvalid = 1'b0; m_axis_tready = 1'b1; drainReq = 1'b0;
    for (int i = 0; i < 40 && (m_cnt > 0 || mq.size() > 0); i++) begin
      sigRelease = RW'(m_cnt > 3 ? 3 : m_cnt);
      cycle();
    end
    sigRelease = '0;
    cycle();
    chk(name, 64'({inFlight, m_axis_tvalid}), 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a0, zc, dc, rh;
    new_payload();
    #2;
    do_reset();

    // Fill to the limit with no releases.
    a0 = dut_acc; s_axis_tvalid = 1'b1; m_axis_tready = 1'b1;
    repeat (10) cycle();
    chk("t1_accepted", 64'(dut_acc - a0), 64'd4);
    chk("t1_inflight", 64'(inFlight), 64'd4);
    chk("t1_released", 64'(released), 64'd0);
    chk("t1_ready_low", 64'(s_axis_tready), 64'd0);

    // Release two, then two more fit.
    s_axis_tvalid = 1'b0; sigRelease = 2'd2;
    cycle();
    chk("t2_inflight", 64'(inFlight), 64'd2);
    chk("t2_ready", 64'(s_axis_tready), 64'd1);
    a0 = dut_acc; s_axis_tvalid = 1'b1; sigRelease = '0;
    repeat (5) cycle();
    chk("t2_accepted", 64'(dut_acc - a0), 64'd2);
    chk("t2_inflight_full", 64'(inFlight), 64'd4);

    // Netting and underflow.
    s_axis_tvalid = 1'b0; sigRelease = 2'd2;
    cycle();
    a0 = dut_acc; s_axis_tvalid = 1'b1; sigRelease = 2'd1;
    cycle();
    chk("t3_net_acc", 64'(dut_acc - a0), 64'd1);
    chk("t3_net_inflight", 64'(inFlight), 64'd2);
    s_axis_tvalid = 1'b0; sigRelease = 2'd1;
    cycle();
    chk("t3_one", 64'(inFlight), 64'd1);
    sigRelease = 2'd3;
    cycle();
    chk("t3_underflow_cnt", 64'(inFlight), 64'd0);
    chk("t3_underflow_err", 64'(errUnderflow), 64'd1);
    sigRelease = '0;
    repeat (3) cycle();
    chk("t3_err_sticky", 64'(errUnderflow), 64'd1);
    seq_check("t3_seq", 1'b0);

    // Random data with downstream ready toggling every cycle.
    do_reset();
    for (int i = 0; i < 300; i++) begin
      m_axis_tready = ~m_axis_tready;
      s_axis_tvalid = ($urandom_range(0, 9) < 7);
      sigRelease = RW'($urandom_range(0, m_cnt > 3 ? 3 : m_cnt));
      cycle();
    end
    drain_all("t4_drain_all");
    chk("t4_beats_moved", 64'(got.size() > 40), 64'd1);
    seq_check("t4_seq", 1'b1);

    // Drain handshake from a count of three.
    do_reset();
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 10 && m_cnt < 3; i++) cycle();
    chk("t5_fill", 64'(inFlight), 64'd3);
    s_axis_tvalid = 1'b0; drainReq = 1'b1; sigRelease = 2'd1;
    cycle();
    s_axis_tvalid = 1'b1;
    zc = -1; dc = -1; rh = 0;
    for (int i = 1; i < 30 && dc < 0; i++) begin
      sigRelease = RW'(m_cnt > 0 ? 1 : 0);
      if (s_axis_tready) rh++;
      cycle();
      if (inFlight == '0 && zc < 0) zc = i;
      if (drained && dc < 0) dc = i;
    end
    chk("t5_ready_low", 64'(rh), 64'd0);
    chk("t5_drained_seen", 64'(dc > 0), 64'd1);
    chk("t5_drained_lat", 64'(dc - zc), 64'd1);
    drainReq = 1'b0; sigRelease = '0;
    cycle();
    chk("t5_undrained", 64'(drained), 64'd0);
    chk("t5_ready_back", 64'(s_axis_tready), 64'd1);
    a0 = dut_acc;
    cycle();
    chk("t5_resume_acc", 64'(dut_acc - a0), 64'd1);
    s_axis_tvalid = 1'b0;
    seq_check("t5_seq", 1'b0);

    // Reset mid-stream with three in flight.
    do_reset();
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 10 && m_cnt < 3; i++) cycle();
    chk("t6_fill", 64'(inFlight), 64'd3);
    seq_check("t6_seq", 1'b0);
    do_reset();

    // Five credit-stall cycles.
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 10 && m_cnt < int'(MAXN); i++) cycle();
    repeat (5) cycle();
    s_axis_tvalid = 1'b0;
    chk("t7_stall_count", 64'(statStallCycles), 64'(EXP_STALL));
    seq_check("t7_seq", 1'b0);
    do_reset();
    chk("t7_stall_cleared", 64'(statStallCycles), 64'd0);

    // Fully random including drain requests and occasional over-release.
    for (int i = 0; i < 400; i++) begin
      m_axis_tready = 1'($urandom);
      s_axis_tvalid = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 19) == 0) drainReq = ~drainReq;
      if ($urandom_range(0, 39) == 0) sigRelease = 2'd3;
      else sigRelease = RW'($urandom_range(0, m_cnt > 3 ? 3 : m_cnt));
      cycle();
    end
    drain_all("t8_drain_all");
    seq_check("t8_seq", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
